slot_dispatcher: RTL
====================

# slot_dispatcher

Consumes the slot table: scans slots round-robin for host-filled (PENDING) entries. For each one it claims the slot, issues the transfer descriptor to the DMA/compute engine over a valid/ready command channel, waits for completion, and writes back DONE status plus a cycle-count profile through the table's write port. Only one job is in flight at a time; it sits between the slot table and the transfer engine.

## Interface
- INDEX_WIDTH, 3, slot index width; 2^INDEX_WIDTH slots scanned
- SRC_ADDR_WIDTH / SRC_SIZE_WIDTH, 32 / 26, source descriptor widths
- DST_ADDR_WIDTH / DST_SIZE_WIDTH, 32 / 26, destination descriptor widths
- STATUS_WIDTH, 2, status field width
- PROFILE_WIDTH, 32, profile counter width
- ST_IDLE / ST_PENDING / ST_RUNNING / ST_DONE, 0 / 1 / 2 / 3, status encodings

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  permits new claims; does not affect a job already claimed
- tbl_out_index  out  INDEX_WIDTH  read index into slot table (table read is combinational, same cycle)
- tbl_src_addr / tbl_src_size / tbl_des_addr / tbl_des_size  in  per params  descriptor of the slot at tbl_out_index
- tbl_status  in  STATUS_WIDTH  status of the slot at tbl_out_index
- tbl_inp_index  out  INDEX_WIDTH  write index
- tbl_inp_status  out  STATUS_WIDTH  status write data
- tbl_inp_profile  out  PROFILE_WIDTH  profile write data
- tbl_set_status / tbl_set_profile  out  1  single-cycle write strobes
- cmd_valid  out  1  command valid
- cmd_ready  in  1  engine accepts command
- cmd_slot  out  INDEX_WIDTH  slot of current command
- cmd_src_addr / cmd_src_size / cmd_des_addr / cmd_des_size  out  per params  latched descriptor
- job_done  in  1  single-cycle completion pulse from engine
- busy  out  1  high in every state except SCAN

## Operation
- States: SCAN, CLAIM, ISSUE, WAIT, WB.
- SCAN: tbl_out_index = scan_ptr.
  - If enable is high and tbl_status == ST_PENDING, latch scan_ptr into cur_slot, latch the four descriptor fields, and go to CLAIM.
  - Otherwise scan_ptr increments by 1 (wraps from 2^INDEX_WIDTH−1 to 0).
  - With enable low, scan_ptr holds.
- CLAIM (1 cycle): tbl_inp_index = cur_slot, tbl_inp_status = ST_RUNNING, tbl_set_status = 1. Profile counter is cleared to 0. Go to ISSUE.
- ISSUE: cmd_valid = 1, with cmd_* driven from the latched registers and held stable. When cmd_valid && cmd_ready, go to WAIT. job_done is ignored in ISSUE, including in the handshake cycle.
- WAIT: on job_done, go to WB.
- Profile counter: increments by 1 in every ISSUE and WAIT cycle, including the job_done cycle. Saturates at all-ones, no wrap.
- WB (1 cycle): tbl_inp_index = cur_slot, tbl_inp_status = ST_DONE, tbl_inp_profile = counter, and tbl_set_status = tbl_set_profile = 1 in the same cycle. Then scan_ptr = cur_slot + 1 (with wrap) and go to SCAN. This gives round-robin fairness: the just-finished slot is examined last.
- Slots in ST_IDLE, ST_RUNNING or ST_DONE are skipped. The dispatcher never writes ST_IDLE; the host clears slots.
- In all other states, write strobes and cmd_valid are 0. tbl_inp_* data is don't-care when its strobe is low, but is driven to 0.

## Timing
- Reset (asynchronous assert): state = SCAN, scan_ptr = 0, cur_slot = 0, counter = 0, descriptor registers = 0. Every output is 0: cmd_valid, busy, strobes, tbl_out_index, cmd_* and tbl_inp_* all 0.
- Reset mid-job returns to SCAN immediately. The slot is left in RUNNING; recovery is the host's job.
- Minimum latency from PENDING seen to cmd_valid: 2 cycles (SCAN hit, CLAIM, then ISSUE).
- Job turnaround with cmd_ready already high and job_done on the first WAIT cycle: SCAN → CLAIM → ISSUE → WAIT → WB = 5 cycles. Profile written = 2.
- Full empty-table sweep (no PENDING): 2^INDEX_WIDTH cycles, returning to the same scan_ptr.
- enable dropping during CLAIM/ISSUE/WAIT/WB has no effect until the return to SCAN.

## Test plan
- Reset: hold reset = 0 with random inputs → all outputs 0, busy = 0. Release → tbl_out_index counts 0,1,…,7,0 while all statuses are IDLE.
- Single job: slot 5 PENDING, src 0x1000/64, dst 0x2000/32, cmd_ready = 1, job_done 3 cycles after the handshake (third WAIT cycle) → status write RUNNING@5, cmd fields match, then status DONE@5 with profile = 4 in one cycle.
- Backpressure: cmd_ready low for 10 cycles, with a job_done pulse asserted during ISSUE → cmd fields stable, done ignored, state stays ISSUE. After the handshake, done on the first WAIT cycle → profile = 12.
- Round-robin: slots 2 and 6 PENDING, with slot 2 re-marked PENDING after it completes → service order is 2, 6, 2.
- Wrap/enable: slot 0 PENDING, scan_ptr = 7, enable low for 5 cycles → no claim, scan_ptr holds. Enable high → scan_ptr wraps 7 → 0 and slot 0 is claimed.
- Async reset asserted in WAIT → outputs 0 immediately. After release, the slot (still RUNNING in the table) is skipped.

Source files
------------

// File: rtl/slot_dispatcher_if.sv
// Slot-table read/write ports and engine command channel seen by the slot dispatcher.
// master = dispatcher side, slave = table/engine side.
interface slot_dispatcher_if #(
    parameter int INDEX_WIDTH    = 3,
    parameter int SRC_ADDR_WIDTH = 32,
    parameter int SRC_SIZE_WIDTH = 26,
    parameter int DST_ADDR_WIDTH = 32,
    parameter int DST_SIZE_WIDTH = 26,
    parameter int STATUS_WIDTH   = 2,
    parameter int PROFILE_WIDTH  = 32
);
    // table read port (combinational read at tbl_out_index)
    logic [INDEX_WIDTH-1:0]    tbl_out_index;
    logic [SRC_ADDR_WIDTH-1:0] tbl_src_addr;
    logic [SRC_SIZE_WIDTH-1:0] tbl_src_size;
    logic [DST_ADDR_WIDTH-1:0] tbl_des_addr;
    logic [DST_SIZE_WIDTH-1:0] tbl_des_size;
    logic [STATUS_WIDTH-1:0]   tbl_status;

    // table write port
    logic [INDEX_WIDTH-1:0]    tbl_inp_index;
    logic [STATUS_WIDTH-1:0]   tbl_inp_status;
    logic [PROFILE_WIDTH-1:0]  tbl_inp_profile;
    logic                      tbl_set_status;
    logic                      tbl_set_profile;

    // engine command channel
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [INDEX_WIDTH-1:0]    cmd_slot;
    logic [SRC_ADDR_WIDTH-1:0] cmd_src_addr;
    logic [SRC_SIZE_WIDTH-1:0] cmd_src_size;
    logic [DST_ADDR_WIDTH-1:0] cmd_des_addr;
    logic [DST_SIZE_WIDTH-1:0] cmd_des_size;
    logic                      job_done;

    modport master (
        output tbl_out_index,
        input  tbl_src_addr, tbl_src_size, tbl_des_addr, tbl_des_size, tbl_status,
        output tbl_inp_index, tbl_inp_status, tbl_inp_profile,
        output tbl_set_status, tbl_set_profile,
        output cmd_valid,
        input  cmd_ready,
        output cmd_slot, cmd_src_addr, cmd_src_size, cmd_des_addr, cmd_des_size,
        input  job_done
    );

    modport slave (
        input  tbl_out_index,
        output tbl_src_addr, tbl_src_size, tbl_des_addr, tbl_des_size, tbl_status,
        input  tbl_inp_index, tbl_inp_status, tbl_inp_profile,
        input  tbl_set_status, tbl_set_profile,
        input  cmd_valid,
        output cmd_ready,
        input  cmd_slot, cmd_src_addr, cmd_src_size, cmd_des_addr, cmd_des_size,
        output job_done
    );
endinterface

// File: rtl/slot_dispatcher.sv
// Round-robin slot-table consumer: claims PENDING slots, issues one engine job at a time, writes DONE + cycle profile.
// Latency: PENDING seen -> cmd_valid in 2 cycles; minimum job turnaround 5 cycles.
// Backpressure: cmd_* held stable while cmd_ready is low; no new claim until the current job is written back.
module slot_dispatcher #(
    parameter int INDEX_WIDTH    = 3,
    parameter int SRC_ADDR_WIDTH = 32,
    parameter int SRC_SIZE_WIDTH = 26,
    parameter int DST_ADDR_WIDTH = 32,
    parameter int DST_SIZE_WIDTH = 26,
    parameter int STATUS_WIDTH   = 2,
    parameter int PROFILE_WIDTH  = 32,
    parameter int ST_IDLE        = 0,
    parameter int ST_PENDING     = 1,
    parameter int ST_RUNNING     = 2,
    parameter int ST_DONE        = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    output logic               busy,
    slot_dispatcher_if.master  bus
);

    localparam logic [STATUS_WIDTH-1:0]  STAT_IDLE    = STATUS_WIDTH'(ST_IDLE);
    localparam logic [STATUS_WIDTH-1:0]  STAT_PENDING = STATUS_WIDTH'(ST_PENDING);
    localparam logic [STATUS_WIDTH-1:0]  STAT_RUNNING = STATUS_WIDTH'(ST_RUNNING);
    localparam logic [STATUS_WIDTH-1:0]  STAT_DONE    = STATUS_WIDTH'(ST_DONE);
    localparam logic [INDEX_WIDTH-1:0]   IDX_ONE      = INDEX_WIDTH'(1);
    localparam logic [PROFILE_WIDTH-1:0] PROF_ONE     = PROFILE_WIDTH'(1);

    typedef struct packed {
        logic [SRC_ADDR_WIDTH-1:0] src_addr;
        logic [SRC_SIZE_WIDTH-1:0] src_size;
        logic [DST_ADDR_WIDTH-1:0] des_addr;
        logic [DST_SIZE_WIDTH-1:0] des_size;
    } desc_t;

    typedef enum logic [2:0] {
        SCAN,
        CLAIM,
        ISSUE,
        WAIT,
        WB
    } state_t;

    state_t                   state_q, state_d;
    logic [INDEX_WIDTH-1:0]   scan_ptr_q, scan_ptr_d;
    logic [INDEX_WIDTH-1:0]   cur_slot_q, cur_slot_d;
    desc_t                    desc_q, desc_d;
    logic [PROFILE_WIDTH-1:0] prof_q, prof_d;
    logic [PROFILE_WIDTH-1:0] prof_inc;

    logic                     cmd_valid_c;
    logic                     set_status_c;
    logic                     set_profile_c;
    logic [INDEX_WIDTH-1:0]   inp_index_c;
    logic [STATUS_WIDTH-1:0]  inp_status_c;
    logic [PROFILE_WIDTH-1:0] inp_profile_c;

    // profile saturates rather than wrapping so a hung job reads as "very long"
    assign prof_inc = (&prof_q) ? prof_q : prof_q + PROF_ONE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= SCAN;
            scan_ptr_q <= '0;
            cur_slot_q <= '0;
            desc_q     <= '0;
            prof_q     <= '0;
        end else begin
            state_q    <= state_d;
            scan_ptr_q <= scan_ptr_d;
            cur_slot_q <= cur_slot_d;
            desc_q     <= desc_d;
            prof_q     <= prof_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        scan_ptr_d    = scan_ptr_q;
        cur_slot_d    = cur_slot_q;
        desc_d        = desc_q;
        prof_d        = prof_q;
        cmd_valid_c   = 1'b0;
        set_status_c  = 1'b0;
        set_profile_c = 1'b0;
        inp_index_c   = '0;
        inp_status_c  = STAT_IDLE;
        inp_profile_c = '0;

        case (state_q)
            SCAN: begin
                if (enable) begin
                    if (bus.tbl_status == STAT_PENDING) begin
                        cur_slot_d      = scan_ptr_q;
                        desc_d.src_addr = bus.tbl_src_addr;
                        desc_d.src_size = bus.tbl_src_size;
                        desc_d.des_addr = bus.tbl_des_addr;
                        desc_d.des_size = bus.tbl_des_size;
                        state_d         = CLAIM;
                    end else begin
                        scan_ptr_d = scan_ptr_q + IDX_ONE;
                    end
                end
            end

            CLAIM: begin
                set_status_c = 1'b1;
                inp_index_c  = cur_slot_q;
                inp_status_c = STAT_RUNNING;
                prof_d       = '0;
                state_d      = ISSUE;
            end

            ISSUE: begin
                // job_done is deliberately not looked at until the command is accepted
                cmd_valid_c = 1'b1;
                prof_d      = prof_inc;
                if (bus.cmd_ready) begin
                    state_d = WAIT;
                end
            end

            WAIT: begin
                prof_d = prof_inc;
                if (bus.job_done) begin
                    state_d = WB;
                end
            end

            WB: begin
                set_status_c  = 1'b1;
                set_profile_c = 1'b1;
                inp_index_c   = cur_slot_q;
                inp_status_c  = STAT_DONE;
                inp_profile_c = prof_q;
                // resume just past the finished slot so it is examined last
                scan_ptr_d    = cur_slot_q + IDX_ONE;
                state_d       = SCAN;
            end

            default: begin
                state_d = SCAN;
            end
        endcase
    end

    assign busy                = (state_q != SCAN);
    assign bus.tbl_out_index   = scan_ptr_q;
    assign bus.tbl_inp_index   = inp_index_c;
    assign bus.tbl_inp_status  = inp_status_c;
    assign bus.tbl_inp_profile = inp_profile_c;
    assign bus.tbl_set_status  = set_status_c;
    assign bus.tbl_set_profile = set_profile_c;
    assign bus.cmd_valid       = cmd_valid_c;
    assign bus.cmd_slot        = cur_slot_q;
    assign bus.cmd_src_addr    = desc_q.src_addr;
    assign bus.cmd_src_size    = desc_q.src_size;
    assign bus.cmd_des_addr    = desc_q.des_addr;
    assign bus.cmd_des_size    = desc_q.des_size;

endmodule
